// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one 16-bit SPI master between N_REQ requesters.
// Define SPI_ARB_TIMEOUT_EN to add the done watchdog and timeout_err output.
module spi_arbiter #(
    parameter int N_REQ          = 4,
    parameter int IDX_W          = 2,
    parameter int START_HOLD     = 40,
    parameter int GAP_CYCLES     = 8,
    parameter int TIMEOUT_CYCLES = 2048
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [16*N_REQ-1:0]  tx_data,
    output logic [N_REQ-1:0]     grant,
    output logic [N_REQ-1:0]     done,
    output logic [15:0]          rx_data,
    output logic [IDX_W-1:0]     rx_owner,
    output logic                 busy,
    output logic                 spi_start,
    output logic [15:0]          spi_tx,
    input  logic [15:0]          spi_rx,
    input  logic                 spi_done
`ifdef SPI_ARB_TIMEOUT_EN
    ,
    output logic                 timeout_err
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_DONE,
        WAIT_LOW,
        GAP
    } state_t;

    localparam int CNT_MAX = (START_HOLD > GAP_CYCLES) ? START_HOLD : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] HOLD_END = CNT_W'(START_HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_END  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONE      = N_REQ'(1);

    state_t state, state_n;

    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] owner_nxt;
    logic [IDX_W-1:0] pick;
    logic             pick_vld;
    logic             done_m, done_s, done_d;
    logic             done_rise;
    logic             to_hit;
    logic             fin_ok;
    logic             fin_to;

    // spi_done comes from the divided-clock domain
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_m <= 1'b0;
            done_s <= 1'b0;
            done_d <= 1'b0;
        end else begin
            done_m <= spi_done;
            done_s <= done_m;
            done_d <= done_s;
        end
    end

    assign done_rise = done_s & ~done_d;

    // Reverse scan so the lowest rotated offset from ptr wins
    always_comb begin
        int idx;
        pick     = ptr;
        pick_vld = 1'b0;
        idx      = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (req[idx]) begin
                pick     = IDX_W'(idx);
                pick_vld = 1'b1;
            end
        end
    end

    assign owner_nxt = (owner == LAST_IDX) ? '0 : owner + 1'b1;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_END = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] tcnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tcnt <= '0;
        end else if (state == WAIT_DONE || state == WAIT_LOW) begin
            tcnt <= tcnt + 1'b1;
        end else begin
            tcnt <= '0;
        end
    end

    assign to_hit = (state == WAIT_DONE || state == WAIT_LOW) &&
                    (tcnt == TO_END);
`else
    assign to_hit = 1'b0;
`endif

    assign fin_ok = (state == WAIT_DONE) && done_rise;
    assign fin_to = (state == WAIT_DONE) && to_hit && !done_rise;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:      if (pick_vld)          state_n = START;
            START:     if (cnt == HOLD_END)   state_n = WAIT_DONE;
            WAIT_DONE: begin
                if (done_rise)                state_n = WAIT_LOW;
                else if (to_hit)              state_n = GAP;
            end
            WAIT_LOW:  if (!done_s || to_hit) state_n = GAP;
            GAP:       if (cnt == GAP_END)    state_n = IDLE;
            default:                          state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            ptr      <= '0;
            owner    <= '0;
            grant    <= '0;
            done     <= '0;
            rx_data  <= '0;
            rx_owner <= '0;
            spi_tx   <= '0;
        end else begin
            done <= '0;
            if (state_n != state)
                cnt <= '0;
            else if (state == START || state == GAP)
                cnt <= cnt + 1'b1;

            if (state == IDLE && pick_vld) begin
                owner  <= pick;
                spi_tx <= tx_data[16*pick +: 16];
                grant  <= ONE << pick;
            end

            if (fin_ok || fin_to) begin
                done     <= ONE << owner;
                grant    <= '0;
                ptr      <= owner_nxt;
                rx_owner <= owner;
                rx_data  <= fin_ok ? spi_rx : 16'hFFFF;
            end
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)     timeout_err <= 1'b0;
        else if (to_hit) timeout_err <= 1'b1;
    end
`endif

    assign busy      = (state != IDLE);
    assign spi_start = (state == START);

endmodule

// File: tb/tb_spi_arbiter.sv
// Scoreboard bench for spi_arbiter with a loopback SPI master model.
// Loopback returns ~{tx[7:0], tx[15:8]}; expected words are hand-computed.
module tb_spi_arbiter;

    localparam int N = 4;

    typedef struct {
        int          owner;
        logic [15:0] word;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [N-1:0]  req;
    logic [16*N-1:0] tx_data = '0;
    logic [N-1:0]  grant;
    logic [N-1:0]  done;
    logic [15:0]   rx_data;
    logic [1:0]    rx_owner;
    logic          busy;
    logic          spi_start;
    logic [15:0]   spi_tx;
    logic [15:0]   spi_rx = '0;
    logic          spi_done = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
    logic          timeout_err;
`endif

    spi_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .tx_data   (tx_data),
        .grant     (grant),
        .done      (done),
        .rx_data   (rx_data),
        .rx_owner  (rx_owner),
        .busy      (busy),
        .spi_start (spi_start),
        .spi_tx    (spi_tx),
        .spi_rx    (spi_rx),
        .spi_done  (spi_done)
`ifdef SPI_ARB_TIMEOUT_EN
        ,
        .timeout_err(timeout_err)
`endif
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   last_done = -1000;
    int   tests = 0;
    int   fails = 0;
    int   issued[N];
    int   served[N];
    exp_t mq[$];
    exp_t dq[$];
    bit   stuck = 1'b0;
    bit   pulse_q = 1'b0;
    exp_t mon_e;

    always @(posedge clk) cyc++;

    always_comb begin
        for (int i = 0; i < N; i++) req[i] = (issued[i] != served[i]);
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic issue(int i, logic [15:0] w, logic [15:0] rsp, bit exp_done);
        exp_t e;
        e.owner = i;
        e.word  = w;
        tx_data[16*i +: 16] = w;
        mq.push_back(e);
        if (exp_done) begin
            e.word = rsp;
            dq.push_back(e);
        end
        issued[i]++;
    endtask

    task automatic settle(string name, int budget);
        int n = 0;
        while ((dq.size() != 0 || busy || req != '0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(n < budget), 32'd1);
        repeat (5) @(negedge clk);
    endtask

    task automatic wait_start(int budget);
        int n = 0;
        while (!spi_start && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_start", 32'(n < budget), 32'd1);
    endtask

    // Monitor: pops one expectation per done pulse
    always @(negedge clk) begin
        if (pulse_q) begin
            chk("done_width", 32'(done), 32'd0);
            pulse_q = 1'b0;
        end
        if (reset && done != '0) begin
            pulse_q   = 1'b1;
            last_done = cyc;
            if (dq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got %b expected none", done);
            end else begin
                mon_e = dq.pop_front();
                chk("done_vec", 32'(done), 32'(1 << mon_e.owner));
                chk("rx_data", 32'(rx_data), 32'(mon_e.word));
                chk("rx_owner", 32'(rx_owner), 32'(mon_e.owner));
                chk("grant_clr", 32'(grant), 32'd0);
            end
            for (int i = 0; i < N; i++)
                if (done[i] && issued[i] != served[i]) served[i]++;
        end
    end

    // Loopback master
    initial begin
        forever begin
            @(negedge clk);
            if (spi_start) begin
                exp_t        e;
                int          k;
                logic [15:0] tx;
                tx = spi_tx;
                chk("gap", 32'((cyc - last_done) >= 8), 32'd1);
                if (mq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_start: got %h expected none", spi_tx);
                end else begin
                    e = mq.pop_front();
                    chk("spi_tx", 32'(spi_tx), 32'(e.word));
                    chk("grant", 32'(grant), 32'(1 << e.owner));
                end
                k = 0;
                while (spi_start && k < 200) begin
                    k++;
                    @(negedge clk);
                end
                chk("start_len", 32'(k), 32'd40);
                if (!stuck) begin
                    repeat (60) @(negedge clk);
                    spi_rx   = ~{tx[7:0], tx[15:8]};
                    spi_done = 1'b1;
                    repeat (30) @(negedge clk);
                    spi_done = 1'b0;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        tests++;
        fails++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            issued[i] = 0;
            served[i] = 0;
        end
        repeat (3) @(negedge clk);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_start", 32'(spi_start), 32'd0);
        chk("rst_tx", 32'(spi_tx), 32'd0);
`ifdef SPI_ARB_TIMEOUT_EN
        chk("rst_terr", 32'(timeout_err), 32'd0);
`endif
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // Contention from pointer 0: order 0,1,2,3,0
        issue(0, 16'h1111, 16'hEEEE, 1'b1);
        issue(1, 16'h2222, 16'hDDDD, 1'b1);
        issue(2, 16'h3333, 16'hCCCC, 1'b1);
        issue(3, 16'h4444, 16'hBBBB, 1'b1);
        issue(0, 16'h1111, 16'hEEEE, 1'b1);
        settle("contention", 2000);

        // Single request, pointer now 1
        issue(1, 16'hA5C3, 16'h3C5A, 1'b1);
        settle("single", 500);

        // Move pointer to 3, then 3,0,3 across the wrap
        issue(2, 16'h00FF, 16'h00FF, 1'b1);
        settle("ptr3", 500);
        issue(3, 16'h8001, 16'hFE7F, 1'b1);
        issue(0, 16'h0F0F, 16'hF0F0, 1'b1);
        issue(3, 16'h8001, 16'hFE7F, 1'b1);
        settle("wrap", 1500);

        // tx_data changes after grant must not reach the master
        issue(0, 16'h1234, 16'hCBED, 1'b1);
        wait_start(100);
        tx_data[15:0] = 16'hFFFF;
        repeat (5) @(negedge clk);
        chk("tx_hold", 32'(spi_tx), 32'h1234);
        settle("midflight", 500);

        // Reset during WAIT_DONE
        issue(1, 16'h5555, 16'hAAAA, 1'b0);
        wait_start(100);
        while (spi_start) @(negedge clk);
        repeat (10) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("mid_grant", 32'(grant), 32'd0);
        chk("mid_done", 32'(done), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_start", 32'(spi_start), 32'd0);
        chk("mid_tx", 32'(spi_tx), 32'd0);
        chk("mid_rx", 32'(rx_data), 32'd0);
        chk("mid_owner", 32'(rx_owner), 32'd0);
        issued[1] = served[1];
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (200) @(negedge clk);
        chk("post_rst_idle", 32'(busy), 32'd0);
        issue(2, 16'hC003, 16'hFC3F, 1'b1);
        settle("after_reset", 500);

`ifdef SPI_ARB_TIMEOUT_EN
        stuck = 1'b1;
        issue(3, 16'hBEEF, 16'hFFFF, 1'b1);
        settle("timeout", 3000);
        chk("terr", 32'(timeout_err), 32'd1);
        stuck = 1'b0;
        issue(0, 16'h0001, 16'hFEFF, 1'b1);
        settle("after_timeout", 500);
        chk("terr_sticky", 32'(timeout_err), 32'd1);
`endif

        chk("mq_empty", 32'(mq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
